// File: rtl/ysyx_22050854_regfile_writer.sv
// Register-file write-back controller: ALU/LSU round-robin arbiter, load extension,
// registered write port and per-register pending scoreboard. Optional forwarding: YSYX_22050854_WB_FWD_EN.
module ysyx_22050854_regfile_writer #(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [1:0]      lsu_size,
    input  logic            lsu_unsigned,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [4:0]      chk_addra,
    input  logic [4:0]      chk_addrb,
    output logic            busy_a,
    output logic            busy_b,
    output logic            fwd_hit_a,
    output logic            fwd_hit_b,
    output logic [XLEN-1:0] fwd_data_a,
    output logic [XLEN-1:0] fwd_data_b
);
    // Both result sources use valid/ready: a transfer happens in any cycle where
    // valid && ready; the source holds valid and payload stable until then.

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    grant_e            last_grant_q, last_grant_d;
    logic              rf_wen_q, rf_wen_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];

    logic              alu_fire, lsu_fire, inc_en;
    logic [XLEN-1:0]   lsu_ext;

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // The loser of a conflict is whichever source was granted last.
    assign alu_ready = !lsu_valid || (last_grant_q == GRANT_LSU);
    assign lsu_ready = !alu_valid || (last_grant_q == GRANT_ALU);
    assign alu_fire  = alu_valid && alu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;

    always_comb begin
        lsu_ext = lsu_data;
        case (lsu_size)
            2'b00:   lsu_ext = {{(XLEN-8){!lsu_unsigned && lsu_data[7]}},   lsu_data[7:0]};
            2'b01:   lsu_ext = {{(XLEN-16){!lsu_unsigned && lsu_data[15]}}, lsu_data[15:0]};
            2'b10:   lsu_ext = {{(XLEN-32){!lsu_unsigned && lsu_data[31]}}, lsu_data[31:0]};
            default: lsu_ext = lsu_data;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (lsu_fire) begin
            last_grant_d = GRANT_LSU;
            rf_wen_d     = (lsu_rd != 5'd0);
            rf_waddr_d   = lsu_rd;
            rf_wdata_d   = lsu_ext;
        end else if (alu_fire) begin
            last_grant_d = GRANT_ALU;
            rf_wen_d     = (alu_rd != 5'd0);
            rf_waddr_d   = alu_rd;
            rf_wdata_d   = alu_data;
        end
    end

    // A write retiring this cycle frees a slot, so a saturated counter can still accept.
    assign issue_ready = (issue_rd == 5'd0) || (cnt_q[issue_rd] != CNT_MAX) ||
                         (rf_wen_q && (rf_waddr_q == issue_rd));
    assign inc_en = issue_valid && (issue_rd != 5'd0) && issue_ready;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            logic inc, dec;
            cnt_d[i] = cnt_q[i];
            inc = inc_en && (issue_rd == 5'(i));
            dec = rf_wen_q && (rf_waddr_q == 5'(i)) && (cnt_q[i] != '0);
            if (i == 0) begin
                cnt_d[i] = '0;
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

`ifdef YSYX_22050854_WB_FWD_EN
    // Last outstanding write is on the port now: hand its value over a cycle early.
    assign fwd_hit_a  = rf_wen_q && (chk_addra != 5'd0) && (rf_waddr_q == chk_addra) &&
                        (cnt_q[chk_addra] == CNT_ONE);
    assign fwd_hit_b  = rf_wen_q && (chk_addrb != 5'd0) && (rf_waddr_q == chk_addrb) &&
                        (cnt_q[chk_addrb] == CNT_ONE);
    assign fwd_data_a = fwd_hit_a ? rf_wdata_q : '0;
    assign fwd_data_b = fwd_hit_b ? rf_wdata_q : '0;
`else
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
`endif

    assign busy_a = (chk_addra != 5'd0) && (cnt_q[chk_addra] != '0) && !fwd_hit_a;
    assign busy_b = (chk_addrb != 5'd0) && (cnt_q[chk_addrb] != '0) && !fwd_hit_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_ALU;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= '0;
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_regfile_writer.sv
// Directed self-checking bench for ysyx_22050854_regfile_writer (both forwarding builds).
module tb_ysyx_22050854_regfile_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  chk_addra, chk_addrb;
  logic        busy_a, busy_b, fwd_hit_a, fwd_hit_b;
  logic [63:0] fwd_data_a, fwd_data_b;

  int n_pass  = 0;
  int n_total = 0;

  ysyx_22050854_regfile_writer dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addra(chk_addra), .chk_addrb(chk_addrb),
    .busy_a(busy_a), .busy_b(busy_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic lsu_load(input logic [63:0] data, input logic [1:0] size, input logic uns,
                          input logic [63:0] exp, input string tag);
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = data; lsu_size = size; lsu_unsigned = uns;
    tick();
    lsu_valid = 1'b0;
    settle();
    check({tag, "_wen"}, {63'd0, rf_wen}, 64'd1);
    check(tag, rf_wdata, exp);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0; lsu_size = 2'b11; lsu_unsigned = 1'b0;
    chk_addra = 5'd0; chk_addrb = 5'd0;
    tick(); tick();
    rst = 1'b0;
    issue_rd = 5'd7; chk_addra = 5'd5; chk_addrb = 5'd3;
    settle();
    check("rst_wen", {63'd0, rf_wen}, 64'd0);
    check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    check("rst_busy_a", {63'd0, busy_a}, 64'd0);
    check("rst_fwd_hit_a", {63'd0, fwd_hit_a}, 64'd0);
    check("rst_fwd_data_a", fwd_data_a, 64'd0);

    // single ALU result to x5 with a matching issue
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    settle();
    check("x5_busy_after_issue", {63'd0, busy_a}, 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    settle();
    check("x5_alu_ready", {63'd0, alu_ready}, 64'd1);
    tick();
    alu_valid = 1'b0;
    settle();
    check("x5_wen", {63'd0, rf_wen}, 64'd1);
    check("x5_waddr", {59'd0, rf_waddr}, 64'd5);
    check("x5_wdata", rf_wdata, 64'h1234);
`ifdef YSYX_22050854_WB_FWD_EN
    check("x5_fwd_busy", {63'd0, busy_a}, 64'd0);
    check("x5_fwd_hit", {63'd0, fwd_hit_a}, 64'd1);
    check("x5_fwd_data", fwd_data_a, 64'h1234);
`else
    check("x5_nofwd_busy", {63'd0, busy_a}, 64'd1);
    check("x5_nofwd_hit", {63'd0, fwd_hit_a}, 64'd0);
    check("x5_nofwd_data", fwd_data_a, 64'd0);
`endif
    tick();
    check("x5_wen_drop", {63'd0, rf_wen}, 64'd0);
    check("x5_busy_clear", {63'd0, busy_a}, 64'd0);

    // ALU/LSU conflict: LSU wins first after reset
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h44; lsu_size = 2'b11;
    settle();
    check("rr_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    check("rr_alu_ready", {63'd0, alu_ready}, 64'd0);
    tick();
    lsu_valid = 1'b0;
    settle();
    check("rr_first_waddr", {59'd0, rf_waddr}, 64'd4);
    check("rr_first_wdata", rf_wdata, 64'h44);
    check("rr_alu_ready2", {63'd0, alu_ready}, 64'd1);
    tick();
    alu_valid = 1'b0;
    settle();
    check("rr_second_wen", {63'd0, rf_wen}, 64'd1);
    check("rr_second_waddr", {59'd0, rf_waddr}, 64'd3);
    check("rr_second_wdata", rf_wdata, 64'h33);
    tick();
    check("x3_no_wrap", {63'd0, busy_b}, 64'd0);

    // load extension
    lsu_load(64'h80, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, "lb_neg");
    lsu_load(64'h80, 2'b00, 1'b1, 64'h0000_0000_0000_0080, "lbu");
    lsu_load(64'h8000_0000, 2'b10, 1'b0, 64'hFFFF_FFFF_8000_0000, "lw_neg");
    lsu_load(64'h1234_8001, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_8001, "lh_neg");
    lsu_load(64'hAAAA_7FFF, 2'b01, 1'b0, 64'h0000_0000_0000_7FFF, "lh_pos");
    lsu_load(64'hDEAD_BEEF_8000_0000, 2'b10, 1'b1, 64'h0000_0000_8000_0000, "lwu");
    lsu_load(64'h1234_5678_9ABC_DE7F, 2'b00, 1'b0, 64'h0000_0000_0000_007F, "lb_pos");
    lsu_load(64'hDEAD_BEEF_CAFE_F00D, 2'b11, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, "ld");
    tick();

    // saturate x7
    issue_valid = 1'b1; issue_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("x7_ready_%0d", i), {63'd0, issue_ready}, 64'd1);
      tick();
    end
    settle();
    check("x7_saturated", {63'd0, issue_ready}, 64'd0);
    issue_valid = 1'b0; chk_addra = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    tick();
    alu_valid = 1'b0;
    settle();
    check("x7_ready_on_write", {63'd0, issue_ready}, 64'd1);
    tick();
    check("x7_ready_after", {63'd0, issue_ready}, 64'd1);
    check("x7_busy_cnt2", {63'd0, busy_a}, 64'd1);
    alu_valid = 1'b1;
    tick(); tick();
    alu_valid = 1'b0;
    tick();
    check("x7_drained", {63'd0, busy_a}, 64'd0);

    // issue and retire the same register in one cycle
    issue_valid = 1'b1; issue_rd = 5'd13;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 64'hD;
    tick();
    alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd13;
    settle();
    check("x13_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    issue_valid = 1'b0; chk_addra = 5'd13;
    settle();
    check("x13_busy_kept", {63'd0, busy_a}, 64'd1);
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    tick();
    check("x13_busy_clear", {63'd0, busy_a}, 64'd0);

    // x0 results and issues
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
    settle();
    check("x0_alu_ready", {63'd0, alu_ready}, 64'd1);
    tick();
    alu_valid = 1'b0;
    settle();
    check("x0_no_wen", {63'd0, rf_wen}, 64'd0);
    issue_valid = 1'b1; issue_rd = 5'd0;
    settle();
    check("x0_issue_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    issue_valid = 1'b0; chk_addra = 5'd0;
    settle();
    check("x0_busy", {63'd0, busy_a}, 64'd0);

    // reset mid-operation
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC;
    tick();
    alu_valid = 1'b0; rst = 1'b1; chk_addra = 5'd12;
    tick();
    rst = 1'b0;
    settle();
    check("rst_mid_wen", {63'd0, rf_wen}, 64'd0);
    check("rst_mid_busy", {63'd0, busy_a}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ysyx_22050854_regfile_writer.md
# ysyx_22050854_regfile_writer

Write-side controller for the integer register file. Arbitrates result returns from the ALU and the LSU, sign/zero-extends load data, and drives one registered write port (wen/waddr/wdata) into the register file. Holds a per-register pending scoreboard so the issue stage can stall on read-after-write hazards. Sits between the execute/memory stages and the register file.

## Interface
- XLEN, 64, data width
- NREG, 32, architectural registers (x0 hard-wired zero)
- CNT_W, 2, width of per-register pending counter
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction with destination issuing this cycle
- issue_rd  in  5  its destination register
- issue_ready  out  1  0 when issue_rd's pending counter is saturated
- alu_valid / alu_ready  in / out  1 / 1  ALU result handshake
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid / lsu_ready  in / out  1 / 1  load result handshake
- lsu_rd  in  5  load destination
- lsu_data  in  XLEN  raw load data, right-aligned
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 double
- lsu_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- chk_addra, chk_addrb  in  5  source registers to check
- busy_a, busy_b  out  1  source has a pending write
- fwd_hit_a, fwd_hit_b  out  1  forwarding valid (see Configuration)
- fwd_data_a, fwd_data_b  out  XLEN  forwarded value

## Operation
- Handshake: transfer when valid && ready; valid must be held with stable payload until accepted.
- Arbitration: round-robin on conflict; register last_grant (reset = ALU, so LSU wins the first conflict). Single requester always granted. Loser's ready = 0.
- No back-pressure from the register file: winner is granted same cycle.
- Load extension: select low 8/16/32/64 bits of lsu_data; fill upper bits with bit 7/15/31 (signed) or zero; size 11 passes through.
- Scoreboard: CNT_W-bit counter per register 1..31. Issue with issue_rd != 0 and issue_ready increments; rf_wen cycle for waddr decrements. Both on same register in one cycle: unchanged.
- issue_ready = 0 only when counter[issue_rd] == max (3) and no decrement for it this cycle; issue_rd == 0 always ready.
- busy_x = (chk_addrx != 0) && counter[chk_addrx] != 0.
- Results to x0 are accepted (ready per arbitration) but produce rf_wen = 0 and no counter change.
- Decrement when counter is 0 is a protocol error: counter stays 0 (no wrap).

## Timing
- Reset values: rf_wen 0, rf_waddr 0, rf_wdata 0, all counters 0, last_grant = ALU, busy_a/b 0, fwd_hit_a/b 0, fwd_data_a/b 0, issue_ready 1.
- Result accepted in cycle N -> rf_wen/waddr/wdata registered, valid in cycle N+1; register file captures at end of N+1; read returns new value from N+2.
- Counter decrement takes effect at the end of N+1, so busy is 1 through N+1 and 0 from N+2 (if no other pending writes).
- Issue in cycle M -> busy visible from M+1.
- Reset asserted mid-operation: in-flight output write dropped (rf_wen 0 next cycle), scoreboard cleared.
- alu_ready, lsu_ready, issue_ready, busy_x are combinational from inputs and state.

## Configuration
- YSYX_22050854_WB_FWD_EN defined: in a cycle where rf_wen = 1 and rf_waddr == chk_addrx != 0 and counter == 1, fwd_hit_x = 1, fwd_data_x = rf_wdata, busy_x = 0 (consumer uses the forwarded value one cycle early).
- Not defined: fwd_hit_x and fwd_data_x tied to 0; busy_x follows the counter only.

## Test plan
- Reset, then ALU result rd=5, data 0x1234 in cycle 1 -> rf_wen=1, waddr=5, wdata=0x1234 in cycle 2; busy for x5 0 in cycle 3.
- ALU (rd=3) and LSU (rd=4) both valid for 2 cycles after reset -> LSU granted first, ALU second; writes in consecutive cycles, x4 then x3.
- LSU data 0x80, size 00, signed -> wdata 0xFFFF_FFFF_FFFF_FF80; unsigned -> 0x80; data 0x8000_0000, size 10, signed -> 0xFFFF_FFFF_8000_0000.
- Issue rd=7 three times -> issue_ready for x7 = 0; ALU write to x7 -> issue_ready 1 next cycle, counter 2, busy still 1.
- ALU result to x0 -> ready 1, rf_wen stays 0, counters unchanged.
- With YSYX_22050854_WB_FWD_EN: one pending write to x9, chk_addra=9 during its rf_wen cycle -> fwd_hit_a=1, fwd_data_a=wdata, busy_a=0; without the macro: busy_a=1, fwd_hit_a=0.
